// File: rtl/cla_sub_pipe.sv
// cla_sub_pipe: pipelined N-bit subtractor d = x - y - Bin (mod 2^N).
// Each SIZE-bit block is a carry-lookahead adder computing x + ~y + ~Bin.
// There is one pipeline stage per block, and the borrow ripples between
// stages, one stage per cycle.
// A valid/ready handshake on both sides gives one result per cycle.
// Stalled stages hold their contents, and bubbles collapse.
// Optional feature macro: CLA_SUB_FLAGS_EN adds registered neg/zero/ovf flags.
// N must be a multiple of SIZE.
module cla_sub_pipe #(
  parameter int N    = 8,
  parameter int SIZE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         Bout
`ifdef CLA_SUB_FLAGS_EN
  ,
  output logic         neg,
  output logic         zero,
  output logic         ovf
`endif
);

  localparam int BLOCKS    = N / SIZE;
  localparam int LAST      = BLOCKS - 1;
  localparam int PREV_LAST = (LAST > 0) ? LAST - 1 : 0;

  // Per-stage state. Each stage holds the following:
  //   - its valid bit;
  //   - the borrow out of its block;
  //   - the difference bits finished so far;
  //   - the full operands, of which the later stages use the upper blocks.
  logic [BLOCKS-1:0] v_q;
  logic [BLOCKS-1:0] b_q;
  logic [N-1:0]      d_q [BLOCKS];
  logic [N-1:0]      x_q [BLOCKS];
  logic [N-1:0]      y_q [BLOCKS];

  // Next-state values each stage would capture if it loads this cycle.
  logic [BLOCKS-1:0] load;
  logic [N-1:0]      d_nxt [BLOCKS];
  logic [BLOCKS-1:0] b_nxt;

  // SIZE-bit lookahead adder: returns {carry_out, sum} for a + b + cin.
  // Each carry is built from flat generate/propagate product terms, not a ripple.
  function automatic logic [SIZE:0] cla_block(
    input logic [SIZE-1:0] a,
    input logic [SIZE-1:0] b,
    input logic            cin
  );
    logic [SIZE-1:0] g;
    logic [SIZE-1:0] p;
    logic [SIZE:0]   c;
    logic            term;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SIZE; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[SIZE], p ^ c[SIZE-1:0]};
  endfunction

  // Ready chain: a stage loads when it, or any stage downstream of it, is empty.
  // A stage also loads when the consumer is taking the final result.
  always_comb begin
    logic any_free;
    load     = '0;
    any_free = 1'b0;
    for (int k = 0; k < BLOCKS; k++) begin
      any_free = out_ready;
      for (int j = k; j < BLOCKS; j++) any_free = any_free | ~v_q[j];
      load[k] = any_free;
    end
  end

  assign in_ready = load[0];

  // Block arithmetic for every stage.
  // Stage 0 works from the ports, with carry-in ~Bin.
  // Each later stage works from the previous stage's operands and its borrow.
  always_comb begin
    logic [SIZE-1:0] a_blk;
    logic [SIZE-1:0] y_blk;
    logic            cin;
    logic [N-1:0]    base;
    logic [SIZE:0]   res;
    int              prev;
    a_blk = '0;
    y_blk = '0;
    cin   = 1'b0;
    base  = '0;
    res   = '0;
    b_nxt = '0;
    for (int k = 0; k < BLOCKS; k++) begin
      prev = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        a_blk = x[SIZE-1:0];
        y_blk = y[SIZE-1:0];
        cin   = ~Bin;
        base  = '0;
      end else begin
        a_blk = x_q[prev][k*SIZE +: SIZE];
        y_blk = y_q[prev][k*SIZE +: SIZE];
        cin   = ~b_q[prev];
        base  = d_q[prev];
      end
      res                     = cla_block(a_blk, ~y_blk, cin);
      d_nxt[k]                = base;
      d_nxt[k][k*SIZE +: SIZE] = res[SIZE-1:0];
      b_nxt[k]                = ~res[SIZE];
    end
  end

  // Pipeline registers: a loading stage takes its predecessor's contents.
  // A stage that is not loading holds everything it has.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      b_q <= '0;
      for (int k = 0; k < BLOCKS; k++) begin
        d_q[k] <= '0;
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < BLOCKS; k++) begin
        if (load[k]) begin
          v_q[k] <= (k == 0) ? in_valid : v_q[(k > 0) ? k - 1 : 0];
          b_q[k] <= b_nxt[k];
          d_q[k] <= d_nxt[k];
          x_q[k] <= (k == 0) ? x : x_q[(k > 0) ? k - 1 : 0];
          y_q[k] <= (k == 0) ? y : y_q[(k > 0) ? k - 1 : 0];
        end
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign d         = d_q[LAST];
  assign Bout      = b_q[LAST];

`ifdef CLA_SUB_FLAGS_EN
  logic xs_q [BLOCKS];
  logic ys_q [BLOCKS];
  logic xs_last;
  logic ys_last;
  logic neg_q;
  logic zero_q;
  logic ovf_q;

  // Operand sign bits seen by the last stage when it loads.
  always_comb begin
    xs_last = x[N-1];
    ys_last = y[N-1];
    if (LAST > 0) begin
      xs_last = xs_q[PREV_LAST];
      ys_last = ys_q[PREV_LAST];
    end
  end

  // Sign-bit pipeline, plus flags registered together with the final difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < BLOCKS; k++) begin
        xs_q[k] <= 1'b0;
        ys_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < BLOCKS; k++) begin
        if (load[k]) begin
          xs_q[k] <= (k == 0) ? x[N-1] : xs_q[(k > 0) ? k - 1 : 0];
          ys_q[k] <= (k == 0) ? y[N-1] : ys_q[(k > 0) ? k - 1 : 0];
        end
      end
      if (load[LAST]) begin
        neg_q  <= d_nxt[LAST][N-1];
        zero_q <= (d_nxt[LAST] == '0);
        ovf_q  <= (xs_last != ys_last) && (d_nxt[LAST][N-1] != xs_last);
      end
    end
  end

  assign neg  = neg_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Self-checking bench for cla_sub_pipe with N=8, SIZE=4.
// Expected results come from an integer-arithmetic reference model and a FIFO queue.
module tb_cla_sub_pipe;

  localparam int N      = 8;
  localparam int SIZE   = 4;
  localparam int BLOCKS = N / SIZE;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] d;
  logic         Bout;
`ifdef CLA_SUB_FLAGS_EN
  logic         neg;
  logic         zero;
  logic         ovf;
`endif

  cla_sub_pipe #(.N(N), .SIZE(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .Bout      (Bout)
`ifdef CLA_SUB_FLAGS_EN
    ,
    .neg       (neg),
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       bout;
    logic       neg;
    logic       zero;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  logic       acc_in, acc_out, obs_v, obs_r, obs_b;
  logic [7:0] obs_d;
`ifdef CLA_SUB_FLAGS_EN
  logic [2:0] obs_f;
`endif

  // Directed vectors: operands and hand-computed results.
  logic [7:0] tx    [5] = '{8'h5A, 8'h10, 8'h10, 8'h00, 8'h80};
  logic [7:0] ty    [5] = '{8'h23, 8'h01, 8'h0F, 8'h01, 8'h01};
  logic       tbi   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] td    [5] = '{8'h37, 8'h0F, 8'h00, 8'hFF, 8'h7F};
  logic       tbo   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0] tflag [5] = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001};

  // Integer reference: unsigned difference gives d and Bout.
  // The signed range test gives ovf.
  function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b, input logic bi);
    exp_t r;
    int   diff, sa, sb, sdiff;
    diff   = int'(a) - int'(b) - int'(bi);
    r.bout = (diff < 0);
    r.d    = 8'((diff + 256) % 256);
    sa     = (int'(a) >= 128) ? int'(a) - 256 : int'(a);
    sb     = (int'(b) >= 128) ? int'(b) - 256 : int'(b);
    sdiff  = sa - sb - int'(bi);
    r.ovf  = (sdiff < -128) || (sdiff > 127);
    r.neg  = r.d[7];
    r.zero = (r.d == 8'h00);
    r.cyc  = 0;
    return r;
  endfunction

  task automatic drive_cycle(input logic rs, input logic iv, input logic [7:0] xi,
                             input logic [7:0] yi, input logic bi, input logic ordy);
    exp_t e;
    @(negedge clk);
    cyc++;
    rst = rs; in_valid = iv; x = xi; y = yi; Bin = bi; out_ready = ordy;
    #1;
    obs_v = out_valid; obs_r = in_ready; obs_d = d; obs_b = Bout;
`ifdef CLA_SUB_FLAGS_EN
    obs_f = {neg, zero, ovf};
`endif
    acc_in  = iv && in_ready && !rs;
    acc_out = out_valid && ordy && !rs;
    if (acc_in) begin
      e = ref_model(xi, yi, bi);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (obs_v !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", obs_v); else passes++;
    checks++; if (obs_d !== 8'h00) $display("[TB] FAIL reset_d: got %h expected 00", obs_d); else passes++;
    checks++; if (obs_b !== 1'b0) $display("[TB] FAIL reset_Bout: got %b expected 0", obs_b); else passes++;
    checks++; if (obs_r !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", obs_r); else passes++;
`ifdef CLA_SUB_FLAGS_EN
    checks++; if (obs_f !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", obs_f); else passes++;
`endif
    exp_q.delete();
  endtask

  task automatic test_directed();
    exp_t e;
    int   got = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 5) drive_cycle(1'b0, 1'b1, tx[i], ty[i], tbi[i], 1'b1);
      else       drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (i < 5) begin
        checks++; if (acc_in !== 1'b1) $display("[TB] FAIL directed_accept: got %b expected 1", acc_in); else passes++;
      end
      if (acc_out) begin
        checks++;
        if (exp_q.size() == 0 || got >= 5) $display("[TB] FAIL directed_spurious: got extra result %h expected none", obs_d);
        else begin
          passes++;
          e = exp_q.pop_front();
          checks++; if (obs_d !== td[got]) $display("[TB] FAIL directed_d[%0d]: got %h expected %h", got, obs_d, td[got]); else passes++;
          checks++; if (obs_b !== tbo[got]) $display("[TB] FAIL directed_Bout[%0d]: got %b expected %b", got, obs_b, tbo[got]); else passes++;
          checks++; if (cyc - e.cyc != BLOCKS) $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", got, cyc - e.cyc, BLOCKS); else passes++;
`ifdef CLA_SUB_FLAGS_EN
          checks++; if (obs_f !== tflag[got]) $display("[TB] FAIL directed_flags[%0d]: got %b expected %b", got, obs_f, tflag[got]); else passes++;
`endif
          got++;
        end
      end
    end
    checks++; if (got != 5) $display("[TB] FAIL directed_count: got %0d expected 5", got); else passes++;
  endtask

  task automatic test_backpressure();
    logic [7:0] px [4];
    logic [7:0] py [4];
    logic       pb [4];
    exp_t       e;
    int         idx = 0, got = 0, last_pop = 0;
    for (int i = 0; i < 4; i++) begin
      px[i] = 8'($urandom_range(0, 63)) + 8'(i * 64);
      py[i] = 8'($urandom);
      pb[i] = 1'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, idx < 4, px[idx % 4], py[idx % 4], pb[idx % 4], 1'b0);
      if (acc_in) idx++;
      if (obs_v && exp_q.size() > 0) begin
        checks++; if (obs_d !== exp_q[0].d) $display("[TB] FAIL stall_d_stable: got %h expected %h", obs_d, exp_q[0].d); else passes++;
        checks++; if (obs_b !== exp_q[0].bout) $display("[TB] FAIL stall_Bout_stable: got %b expected %b", obs_b, exp_q[0].bout); else passes++;
      end
    end
    checks++; if (idx != BLOCKS) $display("[TB] FAIL stall_accepted: got %0d expected %0d", idx, BLOCKS); else passes++;
    checks++; if (obs_r !== 1'b0) $display("[TB] FAIL stall_in_ready: got %b expected 0", obs_r); else passes++;
    checks++; if (obs_v !== 1'b1) $display("[TB] FAIL stall_out_valid: got %b expected 1", obs_v); else passes++;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, idx < 4, px[idx % 4], py[idx % 4], pb[idx % 4], 1'b1);
      if (acc_in) idx++;
      if (acc_out) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL drain_spurious: got result %h expected none", obs_d);
        else begin
          passes++;
          e = exp_q.pop_front();
          checks++; if (obs_d !== e.d) $display("[TB] FAIL drain_d[%0d]: got %h expected %h", got, obs_d, e.d); else passes++;
          checks++; if (obs_b !== e.bout) $display("[TB] FAIL drain_Bout[%0d]: got %b expected %b", got, obs_b, e.bout); else passes++;
          if (got > 0) begin
            checks++; if (cyc != last_pop + 1) $display("[TB] FAIL drain_gap[%0d]: got cycle %0d expected %0d", got, cyc, last_pop + 1); else passes++;
          end
          last_pop = cyc;
          got++;
        end
      end
    end
    checks++; if (got != 4) $display("[TB] FAIL drain_count: got %0d expected 4", got); else passes++;
  endtask

  task automatic test_streaming();
    exp_t e;
    int   got = 0;
    for (int i = 0; i < 26; i++) begin
      drive_cycle(1'b0, i < 16, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      if (i < 16) begin
        checks++; if (acc_in !== 1'b1) $display("[TB] FAIL stream_accept[%0d]: got %b expected 1", i, acc_in); else passes++;
      end
      if (acc_out) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL stream_spurious: got result %h expected none", obs_d);
        else begin
          passes++;
          e = exp_q.pop_front();
          checks++; if (obs_d !== e.d) $display("[TB] FAIL stream_d[%0d]: got %h expected %h", got, obs_d, e.d); else passes++;
          checks++; if (obs_b !== e.bout) $display("[TB] FAIL stream_Bout[%0d]: got %b expected %b", got, obs_b, e.bout); else passes++;
          checks++; if (cyc - e.cyc != BLOCKS) $display("[TB] FAIL stream_latency[%0d]: got %0d expected %0d", got, cyc - e.cyc, BLOCKS); else passes++;
`ifdef CLA_SUB_FLAGS_EN
          checks++; if (obs_f !== {e.neg, e.zero, e.ovf}) $display("[TB] FAIL stream_flags[%0d]: got %b expected %b", got, obs_f, {e.neg, e.zero, e.ovf}); else passes++;
`endif
          got++;
        end
      end
    end
    checks++; if (got != 16) $display("[TB] FAIL stream_count: got %0d expected 16", got); else passes++;
  endtask

  task automatic test_random_handshake();
    exp_t       e;
    logic       cv = 1'b0, cb = 1'b0, ordy;
    logic [7:0] cx = 8'h00, cy = 8'h00;
    for (int i = 0; i < 310; i++) begin
      if (!cv && i < 300 && $urandom_range(0, 3) != 0) begin
        cv = 1'b1; cx = 8'($urandom); cy = 8'($urandom); cb = 1'($urandom);
      end
      if (i >= 300) cv = 1'b0;
      ordy = (i >= 300) || ($urandom_range(0, 9) < 7);
      drive_cycle(1'b0, cv, cx, cy, cb, ordy);
      if (acc_in) cv = 1'b0;
      if (obs_v && !ordy && exp_q.size() > 0) begin
        checks++; if (obs_d !== exp_q[0].d) $display("[TB] FAIL rand_hold_d: got %h expected %h", obs_d, exp_q[0].d); else passes++;
      end
      if (acc_out) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL rand_spurious: got result %h expected none", obs_d);
        else begin
          passes++;
          e = exp_q.pop_front();
          checks++; if (obs_d !== e.d) $display("[TB] FAIL rand_d: got %h expected %h", obs_d, e.d); else passes++;
          checks++; if (obs_b !== e.bout) $display("[TB] FAIL rand_Bout: got %b expected %b", obs_b, e.bout); else passes++;
`ifdef CLA_SUB_FLAGS_EN
          checks++; if (obs_f !== {e.neg, e.zero, e.ovf}) $display("[TB] FAIL rand_flags: got %b expected %b", obs_f, {e.neg, e.zero, e.ovf}); else passes++;
`endif
        end
      end
    end
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL rand_leftover: got %0d pending expected 0", exp_q.size()); else passes++;
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    int   got = 0;
    drive_cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    drive_cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    drive_cycle(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    exp_q.delete();
    drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checks++; if (obs_v !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %b expected 0", obs_v); else passes++;
    checks++; if (obs_d !== 8'h00) $display("[TB] FAIL midrst_d: got %h expected 00", obs_d); else passes++;
    checks++; if (obs_b !== 1'b0) $display("[TB] FAIL midrst_Bout: got %b expected 0", obs_b); else passes++;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      checks++; if (obs_v !== 1'b0) $display("[TB] FAIL midrst_stale[%0d]: got %b expected 0", i, obs_v); else passes++;
    end
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, i == 0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      if (acc_out) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL postrst_spurious: got result %h expected none", obs_d);
        else begin
          passes++;
          e = exp_q.pop_front();
          checks++; if (obs_d !== e.d) $display("[TB] FAIL postrst_d: got %h expected %h", obs_d, e.d); else passes++;
          got++;
        end
      end
    end
    checks++; if (got != 1) $display("[TB] FAIL postrst_count: got %0d expected 1", got); else passes++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; Bin = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_streaming();
    test_random_handshake();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
